// File: rtl/pseudo_spi_rx_intf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : DEFINE_CPU
// Description : Shared constants for the pseudo-SPI receive interface:
//               default bus widths and receive FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package DEFINE_CPU;

    // Default widths for the SRAM port and the frame length field
    localparam int c_MEM_DATA_W = 8;
    localparam int c_MEM_ADDR_W = 10;
    localparam int c_DATA_LEN_W = 8;

    // Receive FSM encodings
    localparam int              c_STATE_W  = 2;
    localparam logic [1:0]      c_ST_IDLE  = 2'd0;
    localparam logic [1:0]      c_ST_ARMED = 2'd1;
    localparam logic [1:0]      c_ST_WRITE = 2'd2;
    localparam logic [1:0]      c_ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pseudo_spi_rx_intf_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_sync
// Description : Two-flop synchronizer for one asynchronous serial input,
//               followed by a rising-edge detector on the synchronized copy.
//               Every serial input uses one instance so all of them carry the
//               same latency.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_sync
    import DEFINE_CPU::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_sync,
    output logic o_rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the raw input through the metastability stage, sync stage and history stage
    always_comb begin
        meta_d = i_din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and edge-history flops, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_sync = sync_q;
    assign o_rise = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/pseudo_spi_rx_intf.sv
`default_nettype none
// ============================================================================
// Module      : pseudo_spi_rx_intf
// Description : Receives bytes over a two-phase pseudo-SPI link (SCLK1 samples
//               SI into a master latch, SCLK2 commits it into the shift
//               register) and writes each completed byte into an SRAM port.
//               BGN arms a frame, LAT terminates it early.
// Options     : PSEUDO_SPI_RX_CKSUM_EN adds output cksum, the XOR of every
//               byte written in the current frame.
// Revision    : 1.0 - initial release
// ============================================================================
module pseudo_spi_rx_intf
    import DEFINE_CPU::*;
#(
    parameter int MEMORY_DATA_WIDTH = c_MEM_DATA_W,
    parameter int MEMORY_ADDR_WIDTH = c_MEM_ADDR_W,
    parameter int RESERVED_DATA_LEN = c_DATA_LEN_W
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         BGN,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
    input  logic                         SCLK1,
    input  logic                         SCLK2,
    input  logic                         LAT,
    input  logic                         SI,
    output logic                         CEN,
    output logic                         WEN,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic [MEMORY_DATA_WIDTH-1:0] D,
    output logic                         spi_MUX,
    output logic                         rx_is_done,
    output logic                         frame_err,
    output logic [RESERVED_DATA_LEN-1:0] byte_cnt
`ifdef PSEUDO_SPI_RX_CKSUM_EN
    ,
    output logic [MEMORY_DATA_WIDTH-1:0] cksum
`endif
);

    localparam int c_BIT_CNT_W = $clog2(MEMORY_DATA_WIDTH);
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = c_BIT_CNT_W'(MEMORY_DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // Serial input synchronizers
    // ------------------------------------------------------------------
    logic w_sclk1_rise, w_sclk2_rise, w_lat_rise, w_si_sync;
    logic w_sclk1_lvl_unused, w_sclk2_lvl_unused, w_lat_lvl_unused, w_si_rise_unused;

    spi_rx_sync u_sync_sclk1 (
        .clk    (CLK),
        .rst_n  (RST_N),
        .i_din  (SCLK1),
        .o_sync (w_sclk1_lvl_unused),
        .o_rise (w_sclk1_rise)
    );

    spi_rx_sync u_sync_sclk2 (
        .clk    (CLK),
        .rst_n  (RST_N),
        .i_din  (SCLK2),
        .o_sync (w_sclk2_lvl_unused),
        .o_rise (w_sclk2_rise)
    );

    spi_rx_sync u_sync_lat (
        .clk    (CLK),
        .rst_n  (RST_N),
        .i_din  (LAT),
        .o_sync (w_lat_lvl_unused),
        .o_rise (w_lat_rise)
    );

    // SI goes through an identical synchronizer so it lines up with SCLK1
    spi_rx_sync u_sync_si (
        .clk    (CLK),
        .rst_n  (RST_N),
        .i_din  (SI),
        .o_sync (w_si_sync),
        .o_rise (w_si_rise_unused)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [c_STATE_W-1:0]         state_q, state_d;
    logic                         bgn_q, bgn_d;
    logic                         master_q, master_d;
    logic [MEMORY_DATA_WIDTH-1:0] shift_q, shift_d;
    logic [c_BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEMORY_ADDR_WIDTH-1:0] a_q, a_d;
    logic [MEMORY_DATA_WIDTH-1:0] d_q, d_d;
    logic [RESERVED_DATA_LEN-1:0] len_q, len_d;
    logic [RESERVED_DATA_LEN-1:0] byte_cnt_q, byte_cnt_d;
    logic                         frame_err_q, frame_err_d;
    logic                         lat_pend_q, lat_pend_d;
`ifdef PSEUDO_SPI_RX_CKSUM_EN
    logic [MEMORY_DATA_WIDTH-1:0] cksum_q, cksum_d;
`endif

    logic                         w_bgn_rise;
    logic                         w_byte_done;
    logic                         w_last_byte;
    logic [MEMORY_DATA_WIDTH-1:0] w_byte;

    assign w_bgn_rise  = BGN & ~bgn_q;
    assign w_byte      = {shift_q[MEMORY_DATA_WIDTH-2:0], master_q};
    assign w_byte_done = w_sclk2_rise && (bit_cnt_q == c_LAST_BIT);
    assign w_last_byte = (byte_cnt_q + RESERVED_DATA_LEN'(1)) == len_q;

    // FSM state register; BGN held high through reset must not look like a rise
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; BGN low forces IDLE from every state
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_bgn_rise) begin
                    state_d = (DATA_LEN == '0) ? c_ST_DONE : c_ST_ARMED;
                end
            end
            c_ST_ARMED: begin
                if (!BGN) begin
                    state_d = c_ST_IDLE;
                end else if (w_byte_done) begin
                    state_d = c_ST_WRITE;
                end else if (w_lat_rise) begin
                    state_d = c_ST_DONE;
                end
            end
            c_ST_WRITE: begin
                if (!BGN) begin
                    state_d = c_ST_IDLE;
                end else if (w_last_byte || lat_pend_q || w_lat_rise) begin
                    state_d = c_ST_DONE;
                end else begin
                    state_d = c_ST_ARMED;
                end
            end
            c_ST_DONE: begin
                if (!BGN) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // FSM outputs: SRAM strobes only in WRITE, ownership from ARMED to DONE
    always_comb begin
        CEN        = (state_q != c_ST_WRITE);
        WEN        = (state_q != c_ST_WRITE);
        spi_MUX    = (state_q != c_ST_IDLE);
        rx_is_done = (state_q == c_ST_DONE);
        A          = a_q;
        D          = d_q;
        frame_err  = frame_err_q;
        byte_cnt   = byte_cnt_q;
`ifdef PSEUDO_SPI_RX_CKSUM_EN
        cksum      = cksum_q;
`endif
    end

    // Datapath next values: frame setup on BGN rise, bit assembly in ARMED,
    // address/count advance on the cycle the write strobe is presented
    always_comb begin
        bgn_d       = BGN;
        master_d    = master_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        addr_d      = addr_q;
        a_d         = a_q;
        d_d         = d_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        frame_err_d = frame_err_q;
        lat_pend_d  = lat_pend_q;
`ifdef PSEUDO_SPI_RX_CKSUM_EN
        cksum_d     = cksum_q;
`endif

        if (w_sclk1_rise) begin
            master_d = w_si_sync;
        end

        if (w_bgn_rise) begin
            addr_d      = ADDR_BGN;
            len_d       = DATA_LEN;
            byte_cnt_d  = '0;
            bit_cnt_d   = '0;
            frame_err_d = 1'b0;
            lat_pend_d  = 1'b0;
`ifdef PSEUDO_SPI_RX_CKSUM_EN
            cksum_d     = '0;
`endif
        end

        if ((state_q == c_ST_ARMED) && BGN) begin
            if (w_sclk2_rise) begin
                shift_d   = w_byte;
                bit_cnt_d = bit_cnt_q + c_BIT_CNT_W'(1);
            end
            if (w_byte_done) begin
                // A LAT rise landing with the final bit still lets that byte through
                a_d        = addr_q;
                d_d        = w_byte;
                bit_cnt_d  = '0;
                lat_pend_d = w_lat_rise;
            end else if (w_lat_rise) begin
                // Any bits already committed mean the frame was cut mid-byte
                frame_err_d = (bit_cnt_q != '0) || w_sclk2_rise;
            end
        end

        if (state_q == c_ST_WRITE) begin
            addr_d     = addr_q + MEMORY_ADDR_WIDTH'(1);
            byte_cnt_d = byte_cnt_q + RESERVED_DATA_LEN'(1);
            lat_pend_d = 1'b0;
`ifdef PSEUDO_SPI_RX_CKSUM_EN
            cksum_d    = cksum_q ^ d_q;
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bgn_q       <= 1'b1;
            master_q    <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            addr_q      <= '0;
            a_q         <= '0;
            d_q         <= '0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            frame_err_q <= 1'b0;
            lat_pend_q  <= 1'b0;
`ifdef PSEUDO_SPI_RX_CKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            bgn_q       <= bgn_d;
            master_q    <= master_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_q      <= addr_d;
            a_q         <= a_d;
            d_q         <= d_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_err_q <= frame_err_d;
            lat_pend_q  <= lat_pend_d;
`ifdef PSEUDO_SPI_RX_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/pseudo_spi_rx_intf.md
PSEUDO_SPI_RX_INTF -- requirements
Module: pseudo_spi_rx_intf

Interface
REQ-001 Parameter MEMORY_DATA_WIDTH, default 8: SRAM word width and bits per received byte.
REQ-002 Parameter MEMORY_ADDR_WIDTH, default 10: SRAM address width.
REQ-003 Parameter RESERVED_DATA_LEN, default 8: width of DATA_LEN.
REQ-004 CLK  in  1  single system clock; all state SHALL change on its rising edge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 BGN  in  1  level; rise arms a receive frame, fall returns block to idle.
REQ-007 ADDR_BGN  in  MEMORY_ADDR_WIDTH  first SRAM address, latched on BGN rise.
REQ-008 DATA_LEN  in  RESERVED_DATA_LEN  byte count, latched on BGN rise.
REQ-009 SCLK1  in  1  phase-1 serial clock; rise samples SI into master latch.
REQ-010 SCLK2  in  1  phase-2 serial clock; rise commits master latch into shift register.
REQ-011 LAT  in  1  frame latch; rise terminates frame.
REQ-012 SI  in  1  serial data, MSB first.
REQ-013 CEN  out  1  SRAM chip enable, active-low.
REQ-014 WEN  out  1  SRAM write enable, active-low.
REQ-015 A  out  MEMORY_ADDR_WIDTH  SRAM address.
REQ-016 D  out  MEMORY_DATA_WIDTH  SRAM write data.
REQ-017 spi_MUX  out  1  high while block owns SRAM port (ARMED..DONE).
REQ-018 rx_is_done  out  1  high in DONE.
REQ-019 frame_err  out  1  sticky per frame; LAT arrived mid-byte.
REQ-020 byte_cnt  out  RESERVED_DATA_LEN  bytes written this frame.

Function
REQ-021 SCLK1, SCLK2, LAT, SI SHALL pass 2-flop synchronizers; edges detected on synchronized copies; SI delay matched to SCLK1.
REQ-022 Serial clocks SHALL be non-overlapping, each high/low >= 3 CLK cycles; faster stimulus is out of scope.
REQ-023 States: IDLE, ARMED, WRITE, DONE.
REQ-024 IDLE -> ARMED on BGN rise with DATA_LEN != 0; IDLE -> DONE on BGN rise with DATA_LEN == 0, no SRAM access.
REQ-025 ARMED: each synchronized SCLK2 rise shifts master latch in at LSB and increments bit count (0..7).
REQ-026 On 8th SCLK2 rise: ARMED -> WRITE; WRITE lasts exactly 1 CLK with CEN=0, WEN=0, A=current address, D=assembled byte.
REQ-027 WRITE strobe SHALL begin no later than 4 CLK cycles after 8th SCLK2 rise at pin.
REQ-028 After WRITE: address += 1 modulo 2^MEMORY_ADDR_WIDTH (1023 -> 0), byte_cnt += 1, bit count cleared; -> DONE if byte_cnt == DATA_LEN, else -> ARMED.
REQ-029 LAT rise in ARMED with bit count 0 -> DONE, frame_err stays 0.
REQ-030 LAT rise in ARMED with bit count 1..7 -> DONE, partial bits discarded, frame_err=1.
REQ-031 LAT rise coinciding with 8th SCLK2 rise: byte SHALL be written, then DONE, frame_err=0.
REQ-032 Serial activity in IDLE or DONE SHALL be ignored.
REQ-033 DONE held while BGN=1; BGN fall in any state -> IDLE next cycle, aborting any frame without a write.
REQ-034 Outside WRITE: CEN=1, WEN=1; A, D hold last values.
REQ-035 frame_err and byte_cnt cleared on BGN rise.

Reset
REQ-036 RST_N=0 at rising CLK: state IDLE, CEN=1, WEN=1, A=0, D=0, spi_MUX=0, rx_is_done=0, frame_err=0, byte_cnt=0, synchronizers and shift register 0.
REQ-037 Reset mid-frame SHALL abort without completing a pending write; BGN high through reset release SHALL NOT arm (rise required).

Configuration
REQ-038 Macro PSEUDO_SPI_RX_CKSUM_EN defined: extra output cksum (MEMORY_DATA_WIDTH) = XOR of all bytes written this frame, cleared on BGN rise and reset.
REQ-039 Macro undefined: no cksum port, no checksum logic; all other behaviour identical.

Structure
REQ-040 State encodings and default widths SHALL reside in the shared DEFINE_CPU package.
REQ-041 Synchronizer plus edge detector SHALL be sub-module spi_rx_sync, one instance per serial input.

Verification
REQ-042 ADDR_BGN=0x010, DATA_LEN=3, bytes 0xA5,0x3C,0xFF -> SRAM[0x010..0x012]=A5,3C,FF, byte_cnt=3, rx_is_done=1, frame_err=0.
REQ-043 ADDR_BGN=0x3FF, DATA_LEN=2, bytes 0x11,0x22 -> writes at 0x3FF then 0x000.
REQ-044 DATA_LEN=4, 2 bytes then 5 bits then LAT -> 2 writes, DONE, frame_err=1, byte_cnt=2.
REQ-045 DATA_LEN=0 -> DONE one cycle after BGN rise, CEN never 0.
REQ-046 DATA_LEN=2, BGN dropped after 11 bits -> IDLE next cycle, exactly 1 write, spi_MUX=0.
REQ-047 With PSEUDO_SPI_RX_CKSUM_EN, bytes 0xA5,0x3C,0xFF -> cksum=0x66.
